bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Parametrised, digit-serial packed-BCD adder/subtractor. It replaces the single-digit combinational BCD adder for multi-digit operands. One decimal digit is processed per clock, least significant first, under a start/ready/done handshake. It sits between the operand registers of the decimal datapath and the result bus, and also flags non-BCD input digits.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only while ready=1
- sub  input  1  0 = add, 1 = subtract (A − B); see Configuration
- A  input  4*DIGITS  packed BCD operand, digit 0 in [3:0]
- B  input  4*DIGITS  packed BCD operand
- Cin  input  1  carry-in (add) / borrow-in (subtract)
- ready  output  1  can accept start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; Sum/Cout/err valid
- Sum  output  4*DIGITS  packed BCD result
- Cout  output  1  decimal carry-out; in subtract, 1 = no borrow
- err  output  1  a latched A or B digit was > 9

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - ready=1, busy=0, done=0.
  - start=1: latch A, B, sub, Cin. Clear err and digit counter. Set carry = Cin (add) or ~Cin (subtract). Go to RUN.
- **RUN**
  - busy=1, ready=0. start is ignored.
  - Each edge processes digit i (counter 0..DIGITS−1).
  - b' = B_i (add) or (9 − B_i) mod 16 (subtract).
  - s = A_i + b' + carry, 5-bit.
  - If s > 9: digit = (s + 6)[3:0], carry = 1. Otherwise digit = s[3:0], carry = 0.
  - Result digits shift into an internal register. err |= (A_i > 9) | (B_i > 9).
  - On the edge processing digit DIGITS−1: load Sum from the result register including that digit, Cout = final carry, update err, go to DONE.
- **DONE**
  - done=1, ready=1, busy=0.
  - start=1 begins a new operation exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- Sum, Cout and err update only on entry to DONE. They hold their value until the next DONE and are never cleared by start.
- Subtract result when Cout=0 is the ten's complement of |A − B|.
- Invalid digits are not corrected. The result follows the arithmetic above, and err is raised.

## Timing
- **Reset** (asynchronous, takes effect immediately, including mid-RUN):
  - Outputs: state=IDLE, ready=1, busy=0, done=0, Sum=0, Cout=0, err=0.
  - Internal: counter and carry cleared. The in-flight operation is discarded.
- **Latency:** start sampled at edge 0. Digits are processed at edges 1..DIGITS. done is high in the cycle after edge DIGITS, for exactly one cycle unless start is accepted in DONE.
- **Throughput:** one operation per DIGITS+1 cycles with back-to-back starts.
- **Operand capture:** A, B, sub and Cin may change freely after the start edge.
- **DIGITS=1:** RUN lasts one edge. done appears 2 cycles after start rises (same rule).

## Configuration
- Macro: BCD_SUB_EN.
- **Defined:** the sub port selects subtraction as described above.
- **Undefined:**
  - The sub input is ignored and the block always adds. The port remains for interface stability.
  - The nine's-complement logic is removed.
  - Cin is always carry-in.

## Test plan
- DIGITS=4, add:
  - 1234 + 5678, Cin=0 → Sum=0x6912, Cout=0, err=0.
  - done rises 5 cycles after start; busy high for 4 cycles.
- Carry chain:
  - 9999 + 0001, Cin=0 → Sum=0x0000, Cout=1.
  - 9999 + 9999, Cin=1 → Sum=0x9999, Cout=1.
- BCD_SUB_EN defined:
  - 1000 − 0001, Cin=0 → Sum=0x0999, Cout=1.
  - 0000 − 0001 → Sum=0x9999, Cout=0.
  - Undefined, same stimulus 1000, 0001, sub=1 → Sum=0x1001, Cout=0.
- Invalid digit:
  - A=0x00A0, B=0x0000 → err=1 with done.
  - Next valid operation clears err to 0 at its done.
- Handshake:
  - start pulsed during RUN has no effect.
  - start held in the DONE cycle: second result arrives DIGITS+1 cycles after the first done, with no IDLE cycle between.
- Reset:
  - rst asserted at digit 2 of RUN → same cycle ready=1, busy=0, Sum=0, Cout=0.
  - A following 0005 + 0005 → Sum=0x0010, Cout=0.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// ============================================================================
// Module : bcd_serial_adder_if
// Handshake and operand/result bundle for the digit-serial BCD adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   A;
  logic [4*DIGITS-1:0]   B;
  logic                  Cin;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   Sum;
  logic                  Cout;
  logic                  err;

  modport master (
    output start, sub, A, B, Cin,
    input  ready, busy, done, Sum, Cout, err
  );

  modport slave (
    input  start, sub, A, B, Cin,
    output ready, busy, done, Sum, Cout, err
  );
endinterface

`default_nettype wire

// File: rtl/bcd_serial_adder.sv
// ============================================================================
// Module : bcd_serial_adder
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional subtraction enabled by defining BCD_SUB_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  bcd_serial_adder_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_q, b_q, res_q, res_next, sum_q;
  logic [CW-1:0]  cnt;
  logic           carry, carry_next, carry_init;
  logic           cout_q, err_acc, err_next, err_q;
  logic           accept, last;
  logic           ready, busy, done;
  logic [3:0]     a_dig, b_dig, b_eff, dig;
  logic [4:0]     s;

  assign a_dig = a_q[3:0];
  assign b_dig = b_q[3:0];

`ifdef BCD_SUB_EN
  logic sub_q;
  // Nine's complement of the B digit; borrow-in enters as an inverted carry
  assign b_eff      = sub_q ? (4'd9 - b_dig) : b_dig;
  assign carry_init = bus.sub ? ~bus.Cin : bus.Cin;
`else
  logic sub_unused;
  assign sub_unused = bus.sub;
  assign b_eff      = b_dig;
  assign carry_init = bus.Cin;
`endif

  assign s = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry};

  always_comb begin
    dig        = s[3:0];
    carry_next = 1'b0;
    if (s > 5'd9) begin
      dig        = s[3:0] + 4'd6;
      carry_next = 1'b1;
    end
  end

  assign err_next = err_acc | (a_dig > 4'd9) | (b_dig > 4'd9);
  assign last     = (cnt == CW'(DIGITS - 1));

  generate
    if (DIGITS == 1) begin : g_single
      assign res_next = dig;
    end else begin : g_multi
      assign res_next = {dig, res_q[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt     <= '0;
      carry   <= 1'b0;
      cout_q  <= 1'b0;
      err_acc <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      cnt     <= '0;
      carry   <= carry_init;
      err_acc <= 1'b0;
`ifdef BCD_SUB_EN
      sub_q   <= bus.sub;
`endif
    end else if (state == RUN) begin
      a_q     <= a_q >> 4;
      b_q     <= b_q >> 4;
      res_q   <= res_next;
      carry   <= carry_next;
      err_acc <= err_next;
      cnt     <= cnt + CW'(1);
      // Visible results change only when the final digit lands
      if (last) begin
        sum_q  <= res_next;
        cout_q <= carry_next;
        err_q  <= err_next;
      end
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.Sum   = sum_q;
  assign bus.Cout  = cout_q;
  assign bus.err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
// ============================================================================
// Module : tb_bcd_serial_adder
// Self-checking bench: vector table, handshake/reset sequences, random ops.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_adder;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();
  bcd_serial_adder #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Decimal reference: whole-number arithmetic modulo 10^DIGITS
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, output logic [W-1:0] sum, output logic cout);
    int p;
    int t;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    t = bcd2int(a) + bcd2int(b) + int'(cin);
`ifdef BCD_SUB_EN
    if (sub) t = bcd2int(a) - bcd2int(b) - int'(cin) + p;
`else
    if (sub) t = t + 0;
`endif
    cout = (t >= p);
    sum  = int2bcd(t % p);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic c, output logic [W-1:0] sum, output logic cout,
                        output logic err, output int edges, output int busy_cyc);
    int guard;
    guard = 0;
    while (!bus.ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.ready) check("ready_wait", 32'(bus.ready), 32'd1);
    bus.A = a; bus.B = b; bus.sub = s; bus.Cin = c; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = W'($urandom); bus.B = W'($urandom);
    bus.sub = 1'($urandom); bus.Cin = 1'($urandom);
    edges = 0;
    busy_cyc = 0;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk); #1;
      edges++;
    end
    sum = bus.Sum; cout = bus.Cout; err = bus.err;
  endtask

  initial begin
    vec_t         vt[8];
    logic [W-1:0] sum, exp_sum;
    logic         cout, err, exp_cout;
    int           edges, busy_cyc;
    logic [W-1:0] ra, rb;
    logic         rs, rc;

    vt[0] = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
    vt[1] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
`ifdef BCD_SUB_EN
    vt[3] = '{16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0999, 1'b1, 1'b0};
    vt[4] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0};
    vt[7] = '{16'h0500, 16'h0200, 1'b1, 1'b1, 16'h0299, 1'b1, 1'b0};
`else
    vt[3] = '{16'h1000, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vt[4] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    vt[7] = '{16'h0500, 16'h0200, 1'b1, 1'b1, 16'h0701, 1'b0, 1'b0};
`endif
    vt[5] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1};
    vt[6] = '{16'h0042, 16'h0058, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};

    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.Sum),   32'd0);
    check("rst_cout",  32'(bus.Cout),  32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].sub, vt[i].cin, sum, cout, err, edges, busy_cyc);
      check($sformatf("vec%0d_sum", i),   32'(sum),   32'(vt[i].sum));
      check($sformatf("vec%0d_cout", i),  32'(cout),  32'(vt[i].cout));
      check($sformatf("vec%0d_err", i),   32'(err),   32'(vt[i].err));
      check($sformatf("vec%0d_lat", i),   32'(edges), 32'(DIGITS));
      check($sformatf("vec%0d_busy", i),  32'(busy_cyc), 32'(DIGITS));
    end

    // start pulsed mid-RUN must be ignored
    @(posedge clk); #1;
    bus.A = 16'h1111; bus.B = 16'h2222; bus.sub = 1'b0; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.A = 16'h9999; bus.B = 16'h9999; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges = 0;
    while (!bus.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("runstart_done", 32'(bus.done), 32'd1);
    check("runstart_sum",  32'(bus.Sum),  32'h3333);
    @(posedge clk); #1;
    check("runstart_idle_busy", 32'(bus.busy), 32'd0);
    check("runstart_idle_done", 32'(bus.done), 32'd0);

    // back-to-back start held in the DONE cycle
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, sum, cout, err, edges, busy_cyc);
    check("b2b_first_sum", 32'(sum), 32'h6912);
    bus.A = 16'h0005; bus.B = 16'h0005; bus.sub = 1'b0; bus.Cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_no_idle", 32'(bus.busy), 32'd1);
    edges = 1;
    while (!bus.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b2b_spacing", 32'(edges), 32'(DIGITS + 1));
    check("b2b_second_sum", 32'(bus.Sum), 32'h0010);

    // asynchronous reset while digit 2 is in flight
    @(posedge clk); #1;
    bus.A = 16'h4321; bus.B = 16'h1111; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_busy",  32'(bus.busy),  32'd0);
    check("midrst_done",  32'(bus.done),  32'd0);
    check("midrst_sum",   32'(bus.Sum),   32'd0);
    check("midrst_cout",  32'(bus.Cout),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(16'h0005, 16'h0005, 1'b0, 1'b0, sum, cout, err, edges, busy_cyc);
    check("postrst_sum",  32'(sum),  32'h0010);
    check("postrst_cout", 32'(cout), 32'd0);
    check("postrst_lat",  32'(edges), 32'(DIGITS));

    // randomized valid operands against the decimal reference
    for (int i = 0; i < 40; i++) begin
      ra = rand_bcd(); rb = rand_bcd();
      rs = 1'($urandom); rc = 1'($urandom);
      model(ra, rb, rs, rc, exp_sum, exp_cout);
      run_op(ra, rb, rs, rc, sum, cout, err, edges, busy_cyc);
      check($sformatf("rnd%0d_sum %h%s%h c%0d", i, ra, rs ? "-" : "+", rb, rc), 32'(sum), 32'(exp_sum));
      check($sformatf("rnd%0d_cout", i), 32'(cout), 32'(exp_cout));
      check($sformatf("rnd%0d_err", i),  32'(err),  32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
